disp_chan_sched: RTL and testbench

Channel scheduler for the 8-channel 32-bit display multiplexer. Drives its 3-bit `Test` select and its `EN` latch strobe: rotates through enabled channels on a dwell timer or manual step, and serialises CPU writes of channel-0 data through a req/ack handshake. Sits between the CPU/board-button logic and the display mux, ahead of the 7-segment driver.

---
 rtl/disp_sched_pkg.sv | 22 ++
 rtl/disp_next_ch.sv | 32 +++
 rtl/disp_chan_sched.sv | 119 +++++++++++
 tb/tb_disp_chan_sched.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// ============================================================================
// Module  : disp_sched_pkg
// Brief   : Shared constants and handshake state type for disp_chan_sched.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package disp_sched_pkg;

    localparam int CH_N             = 8;
    localparam int SEL_W            = 3;
    localparam int DWELL_CYCLES_DEF = 50_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        WAIT_REL = 2'd2
    } hs_state_t;

endpackage

`default_nettype wire

// File: rtl/disp_next_ch.sv
// ============================================================================
// Module  : disp_next_ch
// Brief   : Rotate-priority finder: first mask bit strictly above cur, wrapping.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module disp_next_ch
    import disp_sched_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [CH_N-1:0]  mask,
    output logic [SEL_W-1:0] nxt
);

    logic [SEL_W-1:0] w_idx;

    // Scan offsets from far to near so the nearest enabled channel wins.
    always_comb begin
        nxt   = '0;
        w_idx = '0;
        for (int k = CH_N - 1; k >= 1; k--) begin
            w_idx = cur + SEL_W'(k);
            if (mask[w_idx]) begin
                nxt = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_chan_sched.sv
// ============================================================================
// Module  : disp_chan_sched
// Brief   : Channel scheduler for the 8-channel display mux (step / dwell
//           rotation, CPU channel-0 write handshake). Dwell timer and auto
//           rotation exist only when DISP_SCHED_AUTOSCAN_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module disp_chan_sched
    import disp_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_mode,
    input  logic             step,
    input  logic [CH_N-1:0]  ch_mask,
    input  logic             cpu_wr,
    output logic             cpu_ack,
    output logic [SEL_W-1:0] Test,
    output logic             EN
);

    hs_state_t        state_q, state_d;
    logic [SEL_W-1:0] test_q, test_d;
    logic             en_q, en_d;
    logic             ack_q, ack_d;

    logic [CH_N-1:0]  w_mask_eff;
    logic [SEL_W-1:0] w_nxt;
    logic             w_req;
    logic             w_tc;
    logic             w_adv;
    logic             unused_mask0;

    // Channel 0 is always displayable, so the rotation can never stall.
    assign w_mask_eff   = {ch_mask[CH_N-1:1], 1'b1};
    assign unused_mask0 = ch_mask[0];

    disp_next_ch u_next_ch (
        .cur  (test_q),
        .mask (w_mask_eff),
        .nxt  (w_nxt)
    );

    assign w_req = (state_q == IDLE) && cpu_wr;
    assign w_adv = step || w_tc || !w_mask_eff[test_q];

`ifdef DISP_SCHED_AUTOSCAN_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_tc = auto_mode && (cnt_q == CNT_W'(DWELL_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (!w_req && !w_adv && auto_mode) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [CNT_W-1:0] unused_cfg;

    assign w_tc       = 1'b0;
    assign unused_cfg = CNT_W'(DWELL_CYCLES) ^ {CNT_W{auto_mode}};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (cpu_wr)  state_d = LATCH;
            LATCH:                 state_d = WAIT_REL;
            WAIT_REL: if (!cpu_wr) state_d = IDLE;
            default:               state_d = IDLE;
        endcase

        // A new CPU write pins the mux to channel 0 and swallows any advance.
        test_d = test_q;
        if (w_req) begin
            test_d = '0;
        end else if (w_adv) begin
            test_d = w_nxt;
        end

        en_d  = w_req;
        ack_d = w_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            test_q  <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            test_q  <= test_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    assign Test    = test_q;
    assign EN      = en_q;
    assign cpu_ack = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_chan_sched.sv
// ============================================================================
// Module  : tb_disp_chan_sched
// Brief   : Self-checking bench for disp_chan_sched (vector table, directed
//           corner cases, randomized run against a reference model).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_disp_chan_sched;

    localparam int DW = 4;
`ifdef DISP_SCHED_AUTOSCAN_EN
    localparam bit AUTOSCAN = 1'b1;
`else
    localparam bit AUTOSCAN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       auto_mode = 1'b0;
    logic       step = 1'b0;
    logic [7:0] ch_mask = 8'hFF;
    logic       cpu_wr = 1'b0;
    logic       cpu_ack;
    logic [2:0] test;
    logic       en;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_test;
    int m_cnt;
    bit m_latch;
    bit m_wait;

    typedef struct {
        bit         s;
        bit         wr;
        logic [7:0] mask;
        int         e_test;
        bit         e_en;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    disp_chan_sched #(.DWELL_CYCLES(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .auto_mode (auto_mode),
        .step      (step),
        .ch_mask   (ch_mask),
        .cpu_wr    (cpu_wr),
        .cpu_ack   (cpu_ack),
        .Test      (test),
        .EN        (en)
    );

    function automatic int next_ch(int cur, logic [7:0] mask);
        logic [7:0] eff;
        eff = mask | 8'h01;
        for (int k = 1; k <= 8; k++) begin
            if (eff[(cur + k) % 8]) return (cur + k) % 8;
        end
        return 0;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_test  = 0;
        m_cnt   = 0;
        m_latch = 1'b0;
        m_wait  = 1'b0;
    endtask

    // Applies the behavioural rules for one rising edge using current inputs.
    task automatic model_edge();
        bit         accept;
        bit         timed;
        bit         skip;
        logic [7:0] eff;
        if (rst) begin
            model_reset();
        end else begin
            eff    = ch_mask | 8'h01;
            accept = cpu_wr && !m_latch && !m_wait;
            timed  = AUTOSCAN && auto_mode && (m_cnt == DW - 1);
            skip   = !eff[m_test];
            if (m_latch) begin
                m_latch = 1'b0;
                m_wait  = 1'b1;
            end else if (m_wait) begin
                if (!cpu_wr) m_wait = 1'b0;
            end else if (cpu_wr) begin
                m_latch = 1'b1;
            end
            if (accept) begin
                m_test = 0;
                m_cnt  = 0;
            end else if (step || timed || skip) begin
                m_test = next_ch(m_test, ch_mask);
                m_cnt  = 0;
            end else begin
                m_cnt = (AUTOSCAN && auto_mode) ? m_cnt + 1 : 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_test", int'(test), m_test);
        check("model_en", int'(en), int'(m_latch));
        check("model_ack", int'(cpu_ack), int'(m_latch));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step = 1'b0;
        cpu_wr = 1'b0;
        auto_mode = 1'b0;
        ch_mask = 8'hFF;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check("reset_test", int'(test), 0);
        check("reset_en", int'(en), 0);
        check("reset_ack", int'(cpu_ack), 0);
    endtask

    task automatic add(bit s, bit wr, logic [7:0] mask, int e_test, bit e_en);
        vec_t v;
        v.s = s; v.wr = wr; v.mask = mask; v.e_test = e_test; v.e_en = e_en;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        int first_pulse;

        // Manual stepping, handshake ordering and mask skipping
        for (int i = 1; i <= 9; i++) add(1, 0, 8'hFF, i % 8, 0);
        add(0, 1, 8'hFF, 0, 1);
        add(0, 0, 8'hFF, 0, 0);
        add(1, 0, 8'hA5, 2, 0);
        add(1, 0, 8'hA5, 5, 0);
        add(1, 0, 8'hA5, 7, 0);
        add(1, 0, 8'hA5, 0, 0);
        add(1, 0, 8'h00, 0, 0);
        add(1, 0, 8'h00, 0, 0);
        add(1, 0, 8'hFF, 1, 0);
        add(1, 1, 8'hFF, 0, 1);
        add(0, 1, 8'hFF, 0, 0);
        add(0, 1, 8'hFF, 0, 0);
        add(0, 0, 8'hFF, 0, 0);
        add(0, 1, 8'hFF, 0, 1);
        add(0, 0, 8'hFF, 0, 0);
        add(1, 0, 8'hFF, 1, 0);
        add(1, 0, 8'hFF, 2, 0);
        add(1, 0, 8'hFF, 3, 0);
        add(0, 0, 8'hF7, 4, 0);
        add(0, 0, 8'hF7, 4, 0);

        do_reset();
        foreach (vecs[i]) begin
            step    = vecs[i].s;
            cpu_wr  = vecs[i].wr;
            ch_mask = vecs[i].mask;
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d_test", i), int'(test), vecs[i].e_test);
            check($sformatf("vec%0d_en", i), int'(en), int'(vecs[i].e_en));
            check($sformatf("vec%0d_ack", i), int'(cpu_ack), int'(vecs[i].e_en));
        end
        step = 1'b0;
        cpu_wr = 1'b0;
        ch_mask = 8'hFF;

        // Held request from channel 5: exactly one strobe, first cycle only
        do_reset();
        step = 1'b1;
        repeat (5) tick();
        step = 1'b0;
        check("at_ch5", int'(test), 5);
        cpu_wr = 1'b1;
        pulses = 0;
        first_pulse = -1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (en) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
                check("held_pulse_test", int'(test), 0);
            end
        end
        check("held_pulse_count", pulses, 1);
        check("held_pulse_cycle", first_pulse, 0);
        cpu_wr = 1'b0;
        repeat (2) tick();
        cpu_wr = 1'b1;
        tick();
        check("rearm_en", int'(en), 1);
        check("rearm_ack", int'(cpu_ack), 1);
        cpu_wr = 1'b0;
        repeat (2) tick();

        // Asynchronous reset while in LATCH, request still held afterwards
        cpu_wr = 1'b1;
        tick();
        check("pre_rst_en", int'(en), 1);
        rst = 1'b1;
        #1;
        check("async_rst_en", int'(en), 0);
        check("async_rst_ack", int'(cpu_ack), 0);
        check("async_rst_test", int'(test), 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_en", int'(en), 1);
        tick();
        check("post_rst_en_once", int'(en), 0);
        cpu_wr = 1'b0;
        repeat (2) tick();

`ifdef DISP_SCHED_AUTOSCAN_EN
        // Dwell rotation, with a manual step at counter value 2
        do_reset();
        auto_mode = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step = (c == 7);
            tick();
            check($sformatf("dwell_c%0d", c), int'(test),
                  (c >= 11) ? 3 : (c >= 7) ? 2 : (c >= 4) ? 1 : 0);
        end
        step = 1'b0;
        auto_mode = 1'b0;
`endif

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 15) == 0) ch_mask = 8'($urandom);
            if ($urandom_range(0, 4) == 0) cpu_wr = ~cpu_wr;
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
